// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled UART receiver with optional parity; `define RX_SYNC_EN adds a 2-flop rx synchronizer
module uart_rx_oversampled #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_enable,
    input  logic                  par_type,
    output logic [DATA_WIDTH-1:0] data_out_bus,
    output logic                  data_valid_out,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [PRESCALE_W-1:0] P_ONE    = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  B_ONE    = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    logic rx_s;

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rx_in};
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = rx_in;
`endif

    state_t                  state, state_nxt;
    logic [PRESCALE_W-1:0]   edge_cnt, mid, mid_m1, mid_p1;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic                    s_lo, s_mid, sample, sample_pt, bit_end;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_bad;

    assign mid       = prescale >> 1;
    assign mid_m1    = mid - P_ONE;
    assign mid_p1    = mid + P_ONE;
    assign sample_pt = (edge_cnt == mid_p1);
    assign bit_end   = (edge_cnt == prescale - P_ONE);
    // Majority vote of three samples straddling the bit centre
    assign sample    = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (sample_pt && sample) state_nxt = IDLE;
                     else if (bit_end)        state_nxt = DATA;
            DATA:    if (bit_end && bit_cnt == LAST_BIT)
                         state_nxt = par_enable ? PARITY : STOP;
            PARITY:  if (bit_end) state_nxt = STOP;
            // Leave at the stop sample so a back-to-back start edge is caught
            STOP:    if (sample_pt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt       <= '0;
            bit_cnt        <= '0;
            s_lo           <= 1'b1;
            s_mid          <= 1'b1;
            shift_q        <= '0;
            par_bad        <= 1'b0;
            data_out_bus   <= '0;
            data_valid_out <= 1'b0;
            par_err        <= 1'b0;
            stop_err       <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            par_err        <= 1'b0;
            stop_err       <= 1'b0;

            // The start-edge cycle itself is count 0 of the start bit
            if (state_nxt == IDLE)  edge_cnt <= '0;
            else if (state == IDLE) edge_cnt <= P_ONE;
            else if (bit_end)       edge_cnt <= '0;
            else                    edge_cnt <= edge_cnt + P_ONE;

            if (state_nxt != state) bit_cnt <= '0;
            else if (bit_end)       bit_cnt <= bit_cnt + B_ONE;

            if (edge_cnt == mid_m1) s_lo  <= rx_s;
            if (edge_cnt == mid)    s_mid <= rx_s;

            if (state == START) par_bad <= 1'b0;
            if (state == DATA && sample_pt) shift_q[bit_cnt] <= sample;
            if (state == PARITY && sample_pt) par_bad <= (^shift_q) ^ sample ^ par_type;

            if (state == STOP && sample_pt) begin
                stop_err <= ~sample;
                par_err  <= par_bad;
                if (sample && !par_bad) begin
                    data_valid_out <= 1'b1;
                    data_out_bus   <= shift_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed bench with a frame-level expectation model for uart_rx_oversampled
module tb_uart_rx_oversampled;
    localparam int DEPTH = 4096;
`ifdef RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [7:0] prescale;
    logic       par_enable, par_type;
    logic [7:0] data_out_bus;
    logic       data_valid_out, par_err, stop_err, busy;

    uart_rx_oversampled dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
        .par_enable(par_enable), .par_type(par_type),
        .data_out_bus(data_out_bus), .data_valid_out(data_valid_out),
        .par_err(par_err), .stop_err(stop_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Expected per-cycle behaviour, filled in frame by frame
    logic       v_exp  [DEPTH];
    logic       pe_exp [DEPTH];
    logic       se_exp [DEPTH];
    logic       b_exp  [DEPTH];
    logic [7:0] d_exp  [DEPTH];
    logic [7:0] exp_bus;

    int         n_valid = 0, n_perr = 0, n_serr = 0, last_valid_cyc = 0;
    logic [7:0] valid_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < DEPTH) begin
            if (!rst) begin
                exp_bus = 8'h00;
                chk("rst_valid", 32'(data_valid_out), 0);
                chk("rst_par_err", 32'(par_err), 0);
                chk("rst_stop_err", 32'(stop_err), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_bus", 32'(data_out_bus), 0);
            end else begin
                if (v_exp[cyc]) exp_bus = d_exp[cyc];
                chk("valid", 32'(data_valid_out), 32'(v_exp[cyc]));
                chk("par_err", 32'(par_err), 32'(pe_exp[cyc]));
                chk("stop_err", 32'(stop_err), 32'(se_exp[cyc]));
                chk("busy", 32'(busy), 32'(b_exp[cyc]));
                chk("bus", 32'(data_out_bus), 32'(exp_bus));
            end
        end
        if (data_valid_out === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            valid_log.push_back(data_out_bus);
        end
        if (par_err === 1'b1)  n_perr++;
        if (stop_err === 1'b1) n_serr++;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx_in = 1'b1;
        end
    endtask

    task automatic clear_from(input int c0);
        for (int c = c0; c < DEPTH; c++) begin
            v_exp[c] = 1'b0; pe_exp[c] = 1'b0; se_exp[c] = 1'b0; b_exp[c] = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        clear_from(cyc);
        rst   = 1'b0;
        rx_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

    // A start-bit-only low pulse shorter than the sample point is rejected
    task automatic mark_glitch(input int d, input int p);
        for (int c = d + 1; c < d + p / 2 + 2; c++) b_exp[c] = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input int abort_idx, output int c0);
        int   p, nb, ev;
        logic ok;
        logic bits[11];
        p  = int'(prescale);
        nb = par_enable ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
        bits[9]  = par_enable ? pbit : sbit;
        bits[10] = sbit;
        @(posedge clk); #1;
        c0 = cyc;
        ok = !par_enable || (((^d) ^ pbit) == par_type);
        ev = c0 + (nb - 1) * p + p / 2 + 2 + SYNC;
        for (int c = c0 + 1 + SYNC; c < ev; c++) b_exp[c] = 1'b1;
        v_exp[ev]  = sbit && ok;
        pe_exp[ev] = par_enable && !ok;
        se_exp[ev] = !sbit;
        d_exp[ev]  = d;
        // A low stop bit is still low when the receiver returns to idle
        if (!sbit) mark_glitch(ev, p);
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < p; k++) begin
                if (b != 0 || k != 0) begin
                    @(posedge clk); #1;
                end
                rx_in = bits[b];
                if (b == abort_idx && k == p / 2) begin
                    do_reset(2);
                    return;
                end
            end
        end
    endtask

    int c0, nv, np, ns;

    initial begin
        for (int c = 0; c < DEPTH; c++) begin
            v_exp[c] = 1'b0; pe_exp[c] = 1'b0; se_exp[c] = 1'b0; b_exp[c] = 1'b0; d_exp[c] = 8'h00;
        end
        exp_bus    = 8'h00;
        rst        = 1'b0;
        rx_in      = 1'b1;
        prescale   = 8'd8;
        par_enable = 1'b0;
        par_type   = 1'b0;

        // 1: reset held with a toggling line
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rx_in = ~rx_in;
        end
        @(posedge clk); #1;
        rx_in = 1'b1;
        rst   = 1'b1;
        idle(4);
        chk("t1_busy", 32'(busy), 0);

        // 2: prescale 8, no parity, 0xA5
        nv = n_valid;
        send_frame(8'hA5, 1'b0, 1'b1, -1, c0);
        idle(8);
        chk("t2_bus", 32'(data_out_bus), 32'h A5);
        chk("t2_valid_cnt", 32'(n_valid - nv), 1);
        chk("t2_latency", 32'(last_valid_cyc - c0), 32'(78 + SYNC));

        // 3: prescale 4, even parity, good then bad parity bit
        prescale   = 8'd4;
        par_enable = 1'b1;
        par_type   = 1'b0;
        idle(2);
        nv = n_valid; np = n_perr;
        send_frame(8'h4B, 1'b0, 1'b1, -1, c0);
        idle(8);
        chk("t3_bus_good", 32'(data_out_bus), 32'h4B);
        send_frame(8'h4B, 1'b1, 1'b1, -1, c0);
        idle(8);
        chk("t3_valid_cnt", 32'(n_valid - nv), 1);
        chk("t3_par_err_cnt", 32'(n_perr - np), 1);
        chk("t3_bus_held", 32'(data_out_bus), 32'h4B);

        // 4: prescale 16, low stop bit then a good frame
        prescale   = 8'd16;
        par_enable = 1'b0;
        idle(2);
        nv = n_valid; ns = n_serr;
        send_frame(8'h3C, 1'b0, 1'b0, -1, c0);
        idle(32);
        chk("t4_stop_err_cnt", 32'(n_serr - ns), 1);
        chk("t4_no_valid", 32'(n_valid - nv), 0);
        send_frame(8'h81, 1'b0, 1'b1, -1, c0);
        idle(8);
        chk("t4_bus", 32'(data_out_bus), 32'h81);

        // 5: two-cycle glitch on the start bit
        prescale = 8'd8;
        idle(2);
        nv = n_valid; np = n_perr; ns = n_serr;
        @(posedge clk); #1;
        rx_in = 1'b0;
        mark_glitch(cyc + SYNC, 8);
        @(posedge clk); #1;
        rx_in = 1'b0;
        idle(16);
        chk("t5_strobes", 32'((n_valid - nv) + (n_perr - np) + (n_serr - ns)), 0);
        chk("t5_busy", 32'(busy), 0);

        // 6: back-to-back frames, then a frame cut by reset in data bit 3
        prescale = 8'd4;
        idle(2);
        nv = n_valid;
        send_frame(8'h11, 1'b0, 1'b1, -1, c0);
        send_frame(8'hEE, 1'b0, 1'b1, -1, c0);
        send_frame(8'h5A, 1'b0, 1'b1, 4, c0);
        idle(60);
        chk("t6_valid_cnt", 32'(n_valid - nv), 2);
        if (valid_log.size() >= 2) begin
            chk("t6_first", 32'(valid_log[valid_log.size() - 2]), 32'h11);
            chk("t6_second", 32'(valid_log[valid_log.size() - 1]), 32'hEE);
        end else begin
            chk("t6_log_size", 32'(valid_log.size()), 2);
        end
        chk("t6_bus_after_rst", 32'(data_out_bus), 0);
        chk("t6_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Standalone UART receiver. It recovers 8-bit frames from a serial line using an oversampling clock-enable scheme set by prescale. Parity and stop-bit checking are configurable, and frames are delivered on a parallel bus with a one-cycle valid strobe. It is the receiving end of the serial link driven by the UART transmit path and by bench serial drivers, and it slots into UART_TOP-style integrations as the rx leg.

Parameters:
DATA_WIDTH, 8, payload bits per frame, sent LSB first
PRESCALE_W, 8, width of the prescale port

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rx_in  in  1  serial line, idle high
prescale  in  PRESCALE_W  clock cycles per bit; legal values are even, 4..32
par_enable  in  1  1 = frame carries a parity bit
par_type  in  1  0 = even parity, 1 = odd parity
data_out_bus  out  DATA_WIDTH  last good frame payload
data_valid_out  out  1  one-cycle strobe, good frame
par_err  out  1  one-cycle strobe, parity mismatch
stop_err  out  1  one-cycle strobe, stop bit sampled low
busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Reset: rst low asynchronously forces all state to IDLE and clears both counters.
  - data_out_bus = 0; data_valid_out, par_err, stop_err and busy = 0.
- Config inputs (prescale, par_enable, par_type) are sampled continuously and must be held stable while busy. Changing them mid-frame is undefined.
- Bit timing uses edge_cnt, which counts 0..prescale-1 and then wraps.
  - On wrap, bit_cnt increments.
  - mid = prescale/2.
  - The sample value is the majority of rx at edge_cnt = mid-1, mid and mid+1, and is valid at edge_cnt = mid+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx is seen low, go to START with edge_cnt = 0.
  - START: at the sample point, if the sample is 1 the start bit was a glitch: return to IDLE with no strobe. Otherwise finish the bit, then go to DATA.
  - DATA: shift the sample into bit position bit_cnt (LSB first). After DATA_WIDTH bits, go to PARITY if par_enable is set, else go to STOP.
  - PARITY: at the sample point, compute the check. Even: XOR of payload and parity bit must be 0. Odd: it must be 1. Latch the mismatch. At the end of the bit, go to STOP.
  - STOP: at the sample point, evaluate the frame and go to IDLE immediately, without waiting for the end of the stop bit. This allows resync on a back-to-back start edge.
- Output at STOP evaluation; strobes assert the cycle after the stop sample:
  - Stop sample = 0: stop_err = 1.
  - Parity mismatch latched: par_err = 1.
  - No error: data_valid_out = 1 and data_out_bus loads the payload.
  - Both errors may assert together.
  - On any error, data_out_bus holds its previous value.
- Latency: the valid strobe comes at most (mid+2) cycles into the stop bit.
- busy rises the cycle after the start edge is detected and falls with the return to IDLE.
- Reset asserted mid-frame: the frame is dropped, with no strobe.
  - After release, the FSM waits in IDLE for the next low.
  - A line that is already low at release is treated as a start edge.

Optional Feature:
RX_SYNC_EN
- Defined: rx_in passes through a 2-flop synchronizer, reset to 1. All timing shifts by 2 cycles, and rx_in may be asynchronous to clk.
- Undefined: rx_in is used directly. The source must already be synchronous to clk.

Test Plan:
1. Reset: hold rst = 0 for 5 cycles with rx_in toggling -> all outputs stay 0 and busy = 0.
2. prescale = 8, par_enable = 0, send 0xA5 -> exactly one data_valid_out pulse, data_out_bus = 0xA5, par_err = stop_err = 0.
3. prescale = 4, par_enable = 1, par_type = 0, send 0x4B with parity 0 -> valid, bus = 0x4B. Repeat with parity 1 -> single par_err pulse, no valid, bus stays 0x4B.
4. prescale = 16, send 0x3C with stop bit 0 -> stop_err pulse, no valid. Next good frame 0x81 -> valid, bus = 0x81.
5. prescale = 8, pull rx_in low for 2 cycles then high -> no strobes, busy returns to 0 after the start sample, FSM in IDLE.
6. prescale = 4, send two frames 0x11 and 0xEE with no idle gap, then a third frame with rst pulsed low during its bit 3 -> two valid pulses (0x11, 0xEE), no strobe for the third, FSM in IDLE.
